// File: rtl/control_frecuencia.sv
// control_frecuencia: PWM frequency-selection controller.
// Steps the 3-bit selector `indicador` with the up/down buttons. The four
// digits decoded from `indicador` are time-multiplexed onto a 4-digit
// common-anode 7-segment display. Each digit slot starts with one dead cycle
// that has all anodes off, so the previous digit does not ghost.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   btn_up     debounced level; each rising edge increments indicador
//   btn_down   debounced level; each rising edge decrements indicador
//   n_3..n_0   decoded frequency digits (n_3 most significant)
//   indicador  registered frequency selector
//   cambio     one-cycle pulse when indicador takes a new value
//   an         active-low anode enables, an[k] selects digit k
//   digito     selected digit value (0 when blanked)
//   blank      1 = segments off for the current slot
module control_frecuencia #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CODE  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       n_3,
  input  logic [2:0] n_2,
  input  logic [3:0] n_1,
  input  logic [2:0] n_0,
  output logic [2:0] indicador,
  output logic       cambio,
  output logic [3:0] an,
  output logic [3:0] digito,
  output logic       blank
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0] BLANK_VAL = 4'(BLANK_CODE);

  typedef enum logic [1:0] {D0, D1, D2, D3} scan_state_t;

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       up_q, down_q;
  logic       up_edge, down_edge;
  logic [2:0] indicador_d;
  logic       cambio_d;

  logic [3:0] sel_val;
  logic [3:0] sel_an;
  logic [3:0] an_d;
  logic [3:0] digito_d;
  logic       blank_d;

  // Scan state and slot counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= D0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next scan state: advance one digit at the end of each slot
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      case (state_q)
        D0:      state_d = D1;
        D1:      state_d = D2;
        D2:      state_d = D3;
        D3:      state_d = D0;
        default: state_d = D0;
      endcase
    end
  end

  // Digit selection for the current slot; counter 0 is the dead cycle
  always_comb begin
    sel_val = '0;
    sel_an  = 4'b1111;
    case (state_q)
      D0: begin sel_val = {1'b0, n_0};  sel_an = 4'b1110; end
      D1: begin sel_val = n_1;          sel_an = 4'b1101; end
      D2: begin sel_val = {1'b0, n_2};  sel_an = 4'b1011; end
      D3: begin sel_val = {3'b000, n_3}; sel_an = 4'b0111; end
      default: begin sel_val = '0; sel_an = 4'b1111; end
    endcase
    blank_d  = (sel_val == BLANK_VAL);
    digito_d = blank_d ? 4'd0 : sel_val;
    an_d     = (cnt_q == '0) ? 4'b1111 : sel_an;
  end

  // Button edges; simultaneous up and down cancel out
  assign up_edge   = btn_up & ~up_q;
  assign down_edge = btn_down & ~down_q;

  always_comb begin
    indicador_d = indicador;
    cambio_d    = 1'b0;
    if (up_edge && !down_edge) begin
      indicador_d = indicador + 3'd1;
      cambio_d    = 1'b1;
    end else if (down_edge && !up_edge) begin
      indicador_d = indicador - 3'd1;
      cambio_d    = 1'b1;
    end
  end

  // Selector, button history and display output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      indicador <= '0;
      cambio    <= 1'b0;
      an        <= 4'b1111;
      digito    <= '0;
      blank     <= 1'b1;
    end else begin
      up_q      <= btn_up;
      down_q    <= btn_down;
      indicador <= indicador_d;
      cambio    <= cambio_d;
      an        <= an_d;
      digito    <= digito_d;
      blank     <= blank_d;
    end
  end

endmodule

// File: tb/tb_control_frecuencia.sv
// Directed testbench for control_frecuencia with REFRESH_DIV = 4 and a small
// behavioural frequency-digit decoder closing the loop on indicador.
module tb_control_frecuencia;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       n_3;
  logic [2:0] n_2;
  logic [3:0] n_1;
  logic [2:0] n_0;
  logic [2:0] indicador;
  logic       cambio;
  logic [3:0] an;
  logic [3:0] digito;
  logic       blank;

  int n_checks = 0;
  int n_errors = 0;

  // Expected display model state
  int         s_ph = 0;     // phase (0..15) of the scan state/counter
  logic [2:0] m_ind = '0;   // indicador value the decoder currently sees
  logic [3:0] e_an;
  logic [3:0] e_dig;
  logic       e_blank;

  control_frecuencia #(.REFRESH_DIV(4), .BLANK_CODE(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .n_3       (n_3),
    .n_2       (n_2),
    .n_1       (n_1),
    .n_0       (n_0),
    .indicador (indicador),
    .cambio    (cambio),
    .an        (an),
    .digito    (digito),
    .blank     (blank)
  );

  always #5 clk = ~clk;

  // Frequency digit table {n_3, n_2, n_1, n_0}; n_1 = 10 is a blank digit
  function automatic logic [10:0] freq_digits(input logic [2:0] ind);
    case (ind)
      3'd0:    return {1'b0, 3'd1, 4'd10, 3'd5};
      3'd1:    return {1'b0, 3'd3, 4'd10, 3'd0};
      3'd2:    return {1'b0, 3'd7, 4'd10, 3'd5};
      3'd3:    return {1'b1, 3'd2, 4'd5,  3'd0};
      3'd4:    return {1'b1, 3'd5, 4'd0,  3'd0};
      3'd5:    return {1'b1, 3'd7, 4'd5,  3'd0};
      3'd6:    return {1'b1, 3'd0, 4'd9,  3'd4};
      default: return {1'b0, 3'd0, 4'd10, 3'd2};
    endcase
  endfunction

  assign {n_3, n_2, n_1, n_0} = freq_digits(indicador);

  function automatic logic [3:0] digit_of(input logic [2:0] ind, input int k);
    logic [10:0] d;
    d = freq_digits(ind);
    case (k)
      0:       return {1'b0, d[2:0]};
      1:       return d[6:3];
      2:       return {1'b0, d[9:7]};
      default: return {3'b000, d[10]};
    endcase
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: predict display outputs for this edge, then step the model
  task automatic tick();
    logic       in_rst;
    logic [3:0] one;
    logic [3:0] v;
    int         slot;
    in_rst = !rst;
    one    = 4'b0001;
    if (in_rst) begin
      e_an = 4'b1111; e_dig = 4'd0; e_blank = 1'b1;
    end else begin
      slot    = s_ph / 4;
      v       = digit_of(m_ind, slot);
      e_blank = (v == 4'd10);
      e_dig   = e_blank ? 4'd0 : v;
      e_an    = ((s_ph % 4) == 0) ? 4'b1111 : ~(one << slot);
    end
    @(posedge clk);
    #1;
    s_ph = in_rst ? 0 : (s_ph + 1) % 16;
  endtask

  task automatic check_disp();
    check("an", int'(an), int'(e_an));
    check("digito", int'(digito), int'(e_dig));
    check("blank", int'(blank), int'(e_blank));
  endtask

  task automatic pulse_up();
    btn_up = 1'b1;
    tick();
    m_ind = indicador;
    btn_up = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_three;
    int guard;

    // Reset held with buttons toggling
    for (int i = 0; i < 3; i++) begin
      btn_up   = (i == 0);
      btn_down = (i == 1);
      tick();
      check("rst_ind", int'(indicador), 0);
      check("rst_cambio", int'(cambio), 0);
      check("rst_an", int'(an), 4'hF);
      check("rst_blank", int'(blank), 1);
      check("rst_digito", int'(digito), 0);
    end

    // Two full scans at indicador = 0
    rst = 1'b1;
    m_ind = 3'd0;
    for (int i = 0; i < 32; i++) begin
      tick();
      check_disp();
      check("scan_ind", int'(indicador), 0);
      check("scan_cambio", int'(cambio), 0);
    end

    // Held up button steps exactly once
    btn_up = 1'b1;
    tick();
    check_disp();
    check("up_ind", int'(indicador), 1);
    check("up_cambio", int'(cambio), 1);
    m_ind = 3'd1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_disp();
      check("up_hold_ind", int'(indicador), 1);
      check("up_hold_cambio", int'(cambio), 0);
    end
    btn_up = 1'b0;
    saw_three = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_disp();
      if (an == 4'b1011 && digito == 4'd3) saw_three = 1'b1;
    end
    check("up_d2_shows_3", int'(saw_three), 1);

    // Step back to 0 then wrap down and up
    btn_down = 1'b1; tick(); m_ind = indicador; btn_down = 1'b0; tick();
    check("back_ind", int'(indicador), 0);
    btn_down = 1'b1;
    tick();
    check_disp();
    check("wrap_dn_ind", int'(indicador), 7);
    check("wrap_dn_cambio", int'(cambio), 1);
    m_ind = 3'd7;
    btn_down = 1'b0;
    tick();
    check_disp();
    check("wrap_dn_cambio_off", int'(cambio), 0);
    btn_up = 1'b1;
    tick();
    check_disp();
    check("wrap_up_ind", int'(indicador), 0);
    check("wrap_up_cambio", int'(cambio), 1);
    m_ind = 3'd0;
    btn_up = 1'b0;
    tick();
    check_disp();
    check("wrap_up_cambio_off", int'(cambio), 0);

    // Simultaneous edges at indicador = 4
    for (int i = 0; i < 4; i++) pulse_up();
    check("sim_pre_ind", int'(indicador), 4);
    btn_up = 1'b1;
    btn_down = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_disp();
      check("sim_ind", int'(indicador), 4);
      check("sim_cambio", int'(cambio), 0);
    end
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick();
    check("sim_rel_ind", int'(indicador), 4);
    check("sim_rel_cambio", int'(cambio), 0);

    // Reset mid-scan in D2 at counter 2 with indicador = 5
    pulse_up();
    check("mid_pre_ind", int'(indicador), 5);
    guard = 0;
    while (s_ph != 10 && guard < 20) begin
      tick();
      check_disp();
      guard++;
    end
    check("mid_reach_d2", s_ph, 10);
    rst = 1'b0;
    tick();
    check("mid_rst_an", int'(an), 4'hF);
    check("mid_rst_ind", int'(indicador), 0);
    check("mid_rst_blank", int'(blank), 1);
    check("mid_rst_digito", int'(digito), 0);
    m_ind = 3'd0;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_disp();
      check("mid_scan_ind", int'(indicador), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
